// File: rtl/cache_ctrl.sv
// cache_ctrl: write-back, write-allocate, direct-mapped cache controller.
// Holds its own tag/valid/dirty/data arrays and sequences victim write-back
// and block refill over a mem_req/mem_done handshake. Hit and miss counters
// saturate so that long runs never wrap back to small values.
module cache_ctrl #(
   parameter int ADDR_W      = 10,
   parameter int NUM_BLOCKS  = 4,
   parameter int BLOCK_WORDS = 4,
   parameter int CNT_W       = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cpu_req_valid,
   output logic                      cpu_req_ready,
   input  logic                      cpu_we,
   input  logic [ADDR_W-1:0]         cpu_addr,
   input  logic [31:0]               cpu_wdata,
   output logic                      cpu_resp_valid,
   output logic [31:0]               cpu_rdata,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [32*BLOCK_WORDS-1:0] mem_wdata,
   input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
   input  logic                      mem_done,
   output logic [CNT_W-1:0]          hit_cnt,
   output logic [CNT_W-1:0]          miss_cnt
);

   localparam int TAG_W  = ADDR_W - 6;
   localparam int LINE_W = 32 * BLOCK_WORDS;

   typedef enum logic [1:0] {
      IDLE,
      COMPARE,
      WRITE_BACK,
      ALLOCATE
   } state_t;

   state_t state;

   // Latched request, split into its tag / index / word-offset fields
   logic [TAG_W-1:0] req_tag;
   logic [1:0]       req_idx;
   logic [1:0]       req_word;
   logic             req_we;
   logic [31:0]      req_wdata;
   logic             refill_done;

   // Cache storage
   logic [NUM_BLOCKS-1:0] valid_arr;
   logic [NUM_BLOCKS-1:0] dirty_arr;
   logic [TAG_W-1:0]      tag_arr  [NUM_BLOCKS];
   logic [LINE_W-1:0]     data_arr [NUM_BLOCKS];

   logic hit;
   logic mem_ack;
   logic unused_addr_bits;

   // Byte-lane bits of the address never select anything in a word cache
   assign unused_addr_bits = ^cpu_addr[1:0];

   // Lookup of the latched request against the indexed line
   assign hit = valid_arr[req_idx] && (tag_arr[req_idx] == req_tag);

   // A completion pulse only counts while a memory transaction is open
   assign mem_ack = mem_done && mem_req;

   // Controller FSM: owns the arrays, counters and every registered output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         req_tag        <= '0;
         req_idx        <= '0;
         req_word       <= '0;
         req_we         <= 1'b0;
         req_wdata      <= '0;
         refill_done    <= 1'b0;
         valid_arr      <= '0;
         dirty_arr      <= '0;
         for (int i = 0; i < NUM_BLOCKS; i++) begin
            tag_arr[i]  <= '0;
            data_arr[i] <= '0;
         end
         cpu_req_ready  <= 1'b1;
         cpu_resp_valid <= 1'b0;
         cpu_rdata      <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         hit_cnt        <= '0;
         miss_cnt       <= '0;
      end else begin
         cpu_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req_valid) begin
                  req_tag       <= cpu_addr[ADDR_W-1:6];
                  req_idx       <= cpu_addr[5:4];
                  req_word      <= cpu_addr[3:2];
                  req_we        <= cpu_we;
                  req_wdata     <= cpu_wdata;
                  refill_done   <= 1'b0;
                  cpu_req_ready <= 1'b0;
                  state         <= COMPARE;
               end
            end

            COMPARE: begin
               if (hit) begin
                  if (req_we) begin
                     data_arr[req_idx][{req_word, 5'd0} +: 32] <= req_wdata;
                     dirty_arr[req_idx] <= 1'b1;
                  end else begin
                     cpu_rdata <= data_arr[req_idx][{req_word, 5'd0} +: 32];
                  end
                  if (!refill_done && (hit_cnt != {CNT_W{1'b1}})) begin
                     hit_cnt <= hit_cnt + CNT_W'(1);
                  end
                  cpu_resp_valid <= 1'b1;
                  cpu_req_ready  <= 1'b1;
                  state          <= IDLE;
               end else begin
                  if (miss_cnt != {CNT_W{1'b1}}) begin
                     miss_cnt <= miss_cnt + CNT_W'(1);
                  end
                  mem_req <= 1'b1;
                  if (valid_arr[req_idx] && dirty_arr[req_idx]) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= {tag_arr[req_idx], req_idx, 4'h0};
                     mem_wdata <= data_arr[req_idx];
                     state     <= WRITE_BACK;
                  end else begin
                     mem_we    <= 1'b0;
                     mem_addr  <= {req_tag, req_idx, 4'h0};
                     state     <= ALLOCATE;
                  end
               end
            end

            WRITE_BACK: begin
               if (mem_ack) begin
                  dirty_arr[req_idx] <= 1'b0;
                  mem_we             <= 1'b0;
                  mem_addr           <= {req_tag, req_idx, 4'h0};
                  state              <= ALLOCATE;
               end
            end

            ALLOCATE: begin
               if (mem_ack) begin
                  data_arr[req_idx]  <= mem_rdata;
                  tag_arr[req_idx]   <= req_tag;
                  valid_arr[req_idx] <= 1'b1;
                  dirty_arr[req_idx] <= 1'b0;
                  refill_done        <= 1'b1;
                  mem_req            <= 1'b0;
                  state              <= COMPARE;
               end
            end

            default: begin
               mem_req       <= 1'b0;
               cpu_req_ready <= 1'b1;
               state         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed self-checking bench for cache_ctrl.
// The bench plays both the CPU and main memory, driving inputs on the falling
// edge and sampling outputs on the falling edge, away from the active edge.
module tb_cache_ctrl;

   logic         clk;
   logic         rst_n;
   logic         cpu_req_valid;
   logic         cpu_req_ready;
   logic         cpu_we;
   logic [9:0]   cpu_addr;
   logic [31:0]  cpu_wdata;
   logic         cpu_resp_valid;
   logic [31:0]  cpu_rdata;
   logic         mem_req;
   logic         mem_we;
   logic [9:0]   mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_done;
   logic [15:0]  hit_cnt;
   logic [15:0]  miss_cnt;

   int vectorCount = 0;
   int errorCount  = 0;

   cache_ctrl #(
      .ADDR_W(10),
      .NUM_BLOCKS(4),
      .BLOCK_WORDS(4),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .cpu_req_valid(cpu_req_valid),
      .cpu_req_ready(cpu_req_ready),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_resp_valid(cpu_resp_valid),
      .cpu_rdata(cpu_rdata),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_done(mem_done),
      .hit_cnt(hit_cnt),
      .miss_cnt(miss_cnt)
   );

   // Free-running 10-time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs
   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Present one CPU request once the controller is ready, hold it for the accept edge
   task automatic applyStimulus(input logic we, input logic [9:0] addr,
                                input logic [31:0] wdata);
      int n;
      n = 0;
      @(negedge clk);
      while (cpu_req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) checkOutput("req_ready_timeout", 0, 1);
      cpu_we        = we;
      cpu_addr      = addr;
      cpu_wdata     = wdata;
      cpu_req_valid = 1'b1;
      @(negedge clk);
      cpu_req_valid = 1'b0;
   endtask

   // Wait (bounded) until the controller opens a memory transaction
   task automatic waitMemReq(input string tag);
      int n;
      n = 0;
      while (mem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (mem_req !== 1'b1) checkOutput(tag, 0, 1);
   endtask

   // Complete the open memory transaction with a one-cycle done pulse
   task automatic pulseMemDone(input logic [127:0] rdata);
      mem_rdata = rdata;
      mem_done  = 1'b1;
      @(negedge clk);
      mem_done  = 1'b0;
   endtask

   // Wait (bounded) for the response pulse, reporting its latency in cycles
   task automatic waitResp(output int cycles, output logic [31:0] rdata,
                           output logic sawMemReq);
      cycles    = 0;
      sawMemReq = 1'b0;
      do begin
         @(negedge clk);
         cycles++;
         if (mem_req === 1'b1) sawMemReq = 1'b1;
      end while (cpu_resp_valid !== 1'b1 && cycles < 20);
      if (cpu_resp_valid !== 1'b1) checkOutput("resp_timeout", 0, 1);
      rdata = cpu_rdata;
      checkOutput("resp_mem_exclusive", mem_req, 0);
   endtask

   // Directed test sequence
   initial begin
      int          cycles;
      logic [31:0] rdata;
      logic        sawMemReq;
      logic        stable;
      logic        readyLow;
      logic        quiet;

      rst_n         = 1'b0;
      cpu_req_valid = 1'b0;
      cpu_we        = 1'b0;
      cpu_addr      = '0;
      cpu_wdata     = '0;
      mem_rdata     = '0;
      mem_done      = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // T1: reset state, then cold read miss of 0x010
      checkOutput("rst_ready", cpu_req_ready, 1);
      checkOutput("rst_resp", cpu_resp_valid, 0);
      checkOutput("rst_mem_req", mem_req, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_rdata", cpu_rdata, 0);
      checkOutput("rst_hit_cnt", hit_cnt, 0);
      checkOutput("rst_miss_cnt", miss_cnt, 0);

      applyStimulus(1'b0, 10'h010, 32'h0);
      checkOutput("t1_ready_busy", cpu_req_ready, 0);
      waitMemReq("t1_mem_req_timeout");
      checkOutput("t1_mem_we", mem_we, 0);
      checkOutput("t1_mem_addr", mem_addr, 10'h010);
      pulseMemDone(128'h00000004_00000003_00000002_00000001);
      waitResp(cycles, rdata, sawMemReq);
      checkOutput("t1_resp_latency", cycles, 1);
      checkOutput("t1_rdata", rdata, 32'h1);
      checkOutput("t1_miss_cnt", miss_cnt, 1);
      checkOutput("t1_hit_cnt", hit_cnt, 0);

      // T2: read hit of the next word in the same line
      applyStimulus(1'b0, 10'h014, 32'h0);
      waitResp(cycles, rdata, sawMemReq);
      checkOutput("t2_resp_latency", cycles, 1);
      checkOutput("t2_rdata", rdata, 32'h2);
      checkOutput("t2_no_mem_req", sawMemReq, 0);
      checkOutput("t2_hit_cnt", hit_cnt, 1);

      // T3: write hit dirties the line, conflicting read forces a write-back
      applyStimulus(1'b1, 10'h018, 32'hDEADBEEF);
      waitResp(cycles, rdata, sawMemReq);
      checkOutput("t3_write_latency", cycles, 1);
      checkOutput("t3_write_no_mem", sawMemReq, 0);
      checkOutput("t3_hit_cnt", hit_cnt, 2);

      applyStimulus(1'b0, 10'h118, 32'h0);
      waitMemReq("t3_wb_timeout");
      checkOutput("t3_wb_we", mem_we, 1);
      checkOutput("t3_wb_addr", mem_addr, 10'h010);
      checkOutput("t3_wb_data", mem_wdata, 128'h00000004_DEADBEEF_00000002_00000001);
      checkOutput("t3_miss_cnt", miss_cnt, 2);
      pulseMemDone(128'h0);
      checkOutput("t3_refill_req", mem_req, 1);
      checkOutput("t3_refill_we", mem_we, 0);
      checkOutput("t3_refill_addr", mem_addr, 10'h110);

      // T4: slow memory during refill, with an ignored CPU request pulse
      stable   = 1'b1;
      readyLow = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            cpu_we        = 1'b1;
            cpu_addr      = 10'h020;
            cpu_wdata     = 32'h12345678;
            cpu_req_valid = 1'b1;
         end
         if (i == 2) cpu_req_valid = 1'b0;
         @(negedge clk);
         if (mem_req !== 1'b1 || mem_addr !== 10'h110 || mem_we !== 1'b0) stable = 1'b0;
         if (cpu_req_ready !== 1'b0) readyLow = 1'b0;
      end
      checkOutput("t4_mem_stable", stable, 1);
      checkOutput("t4_ready_low", readyLow, 1);
      pulseMemDone(128'h00000044_00000033_00000022_00000011);
      waitResp(cycles, rdata, sawMemReq);
      checkOutput("t4_resp_latency", cycles, 1);
      checkOutput("t4_rdata", rdata, 32'h33);
      checkOutput("t4_miss_cnt", miss_cnt, 2);
      checkOutput("t4_hit_cnt", hit_cnt, 2);
      quiet = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (cpu_resp_valid !== 1'b0 || mem_req !== 1'b0 || cpu_req_ready !== 1'b1) quiet = 1'b0;
      end
      checkOutput("t4_pulse_not_latched", quiet, 1);

      // T5: reset in the middle of a refill
      applyStimulus(1'b0, 10'h220, 32'h0);
      waitMemReq("t5_mem_req_timeout");
      checkOutput("t5_mem_addr", mem_addr, 10'h220);
      checkOutput("t5_miss_before_rst", miss_cnt, 3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t5_mem_req_drop", mem_req, 0);
      checkOutput("t5_hit_cnt_clr", hit_cnt, 0);
      checkOutput("t5_miss_cnt_clr", miss_cnt, 0);
      checkOutput("t5_ready", cpu_req_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b0, 10'h224, 32'h0);
      waitMemReq("t5_rereq_timeout");
      checkOutput("t5_rereq_addr", mem_addr, 10'h220);
      checkOutput("t5_rereq_miss", miss_cnt, 1);
      pulseMemDone(128'h000000A4_000000A3_000000A2_000000A1);
      waitResp(cycles, rdata, sawMemReq);
      checkOutput("t5_rdata", rdata, 32'hA2);
      checkOutput("t5_hit_cnt", hit_cnt, 0);

      // T6: stray mem_done while idle must change nothing
      @(negedge clk);
      mem_rdata = {4{32'hFFFFFFFF}};
      mem_done  = 1'b1;
      @(negedge clk);
      mem_done  = 1'b0;
      quiet = 1'b1;
      repeat (3) begin
         if (cpu_resp_valid !== 1'b0 || mem_req !== 1'b0 || cpu_req_ready !== 1'b1) quiet = 1'b0;
         @(negedge clk);
      end
      checkOutput("t6_idle_quiet", quiet, 1);
      applyStimulus(1'b0, 10'h228, 32'h0);
      waitResp(cycles, rdata, sawMemReq);
      checkOutput("t6_hit_latency", cycles, 1);
      checkOutput("t6_rdata", rdata, 32'hA3);
      checkOutput("t6_no_mem_req", sawMemReq, 0);
      checkOutput("t6_hit_cnt", hit_cnt, 1);
      checkOutput("t6_miss_cnt", miss_cnt, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, errorCount);
      $finish;
   end

endmodule
